fetch_unit: RTL and testbench

//   Instruction-fetch stage of the SISC datapath, directly upstream of the control FSM.

---
 rtl/fetch_unit_if.sv | 38 +++
 rtl/fetch_unit.sv | 90 +++++++++
 tb/tb_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: control strobes and instruction-memory data into the fetch
// stage; PC, IR, decoded fields and status back out.
//   master : control FSM / memory side (drives strobes and imem_data)
//   slave  : fetch_unit side (drives imem_addr, ir, fields, halted, fetch_count)
interface fetch_unit_if #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned CNT_W   = 16
) ();

  logic               pc_rst;
  logic               pc_write;
  logic               pc_sel;
  logic               br_sel;
  logic               ir_load;
  logic [INSTR_W-1:0] imem_data;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] ir;
  logic [3:0]         opcode;
  logic [3:0]         mm;
  logic [3:0]         rd;
  logic [3:0]         rs;
  logic [3:0]         rt;
  logic [15:0]        imm;
  logic               halted;
  logic [CNT_W-1:0]   fetch_count;

  modport master (
    output pc_rst, pc_write, pc_sel, br_sel, ir_load, imem_data,
    input  imem_addr, ir, opcode, mm, rd, rs, rt, imm, halted, fetch_count
  );

  modport slave (
    input  pc_rst, pc_write, pc_sel, br_sel, ir_load, imem_data,
    output imem_addr, ir, opcode, mm, rd, rs, rt, imm, halted, fetch_count
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, instruction register, branch-target
// computation and IR field decode. Acts only on strobes from the control FSM.
// Ports:
//   clk   : system clock, rising edge
//   rst_f : asynchronous active-low reset
//   bus   : fetch_unit_if.slave -- strobes/imem_data in; imem_addr (=PC), ir,
//           opcode/mm/rd/rs/rt/imm fields, halted, fetch_count out
module fetch_unit #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic          clk,
  input  logic          rst_f,
  fetch_unit_if.slave   bus
);

  localparam logic [3:0] OpHlt = 4'hF;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [15:0]        imm;
  logic [ADDR_W-1:0]  tgt_abs;
  logic [ADDR_W-1:0]  tgt_rel;

  assign imm     = ir_q[15:0];
  // Absolute target zero-extends/truncates; relative offset sign-extends.
  assign tgt_abs = ADDR_W'(imm);
  assign tgt_rel = pc_q + ADDR_W'($signed(imm));

  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;

    // pc_rst outranks the halt latch so ctrl can always rewind the PC.
    if (bus.pc_rst) begin
      pc_d = '0;
    end else if (!halted_q && bus.pc_write) begin
      if (!bus.pc_sel) begin
        pc_d = pc_q + ADDR_W'(1);
      end else if (bus.br_sel) begin
        pc_d = tgt_abs;
      end else begin
        pc_d = tgt_rel;
      end
    end

    // IR captures the word at the pre-edge PC, even when PC advances on the same edge.
    if (bus.ir_load && !halted_q) begin
      ir_d = bus.imem_data;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (bus.imem_data[31:28] == OpHlt) begin
        halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      pc_q     <= '0;
      ir_q     <= '0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.ir          = ir_q;
  assign bus.opcode      = ir_q[31:28];
  assign bus.mm          = ir_q[27:24];
  assign bus.rd          = ir_q[23:20];
  assign bus.rs          = ir_q[19:16];
  assign bus.rt          = ir_q[15:12];
  assign bus.imm         = imm;
  assign bus.halted      = halted_q;
  assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic clk;
  logic rst_f;

  fetch_unit_if #(.ADDR_W(16), .INSTR_W(32), .CNT_W(16)) bus ();

  fetch_unit #(.ADDR_W(16), .INSTR_W(32), .CNT_W(16)) u_dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus)
  );

  logic [31:0] imem [0:65535];
  assign bus.imem_data = imem[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state (plain integers, spec rules).
  int          m_pc;
  logic [31:0] m_ir;
  bit          m_halted;
  int          m_cnt;

  task automatic model_reset();
    m_pc = 0; m_ir = '0; m_halted = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit rst, input bit w, input bit sel, input bit br,
                            input bit ld);
    int          nxt;
    int          off;
    logic [31:0] word;
    word = imem[m_pc];
    off  = int'(m_ir[15:0]);
    if (off >= 32768) off = off - 65536;
    nxt = m_pc;
    if (rst) nxt = 0;
    else if (m_halted) nxt = m_pc;
    else if (w) begin
      if (!sel) nxt = (m_pc + 1) % 65536;
      else if (br) nxt = int'(m_ir[15:0]);
      else nxt = (m_pc + off + 65536) % 65536;
    end
    if (ld && !m_halted) begin
      m_ir = word;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (word[31:28] == 4'hF) m_halted = 1;
    end
    m_pc = nxt;
  endtask

  task automatic drive_cycle(input bit rst, input bit w, input bit sel, input bit br,
                             input bit ld);
    @(negedge clk);
    bus.pc_rst   = rst;
    bus.pc_write = w;
    bus.pc_sel   = sel;
    bus.br_sel   = br;
    bus.ir_load  = ld;
    model_step(rst, w, sel, br, ld);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_strobes();
    bus.pc_rst = 0; bus.pc_write = 0; bus.pc_sel = 0; bus.br_sel = 0; bus.ir_load = 0;
  endtask

  // Async assert away from any clock edge; released at the next negedge.
  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst_f = 1'b0;
    idle_strobes();
    model_reset();
    #1;
    @(negedge clk);
    rst_f = 1'b1;
  endtask

  task automatic test_reset();
    // Reach PC=0x0123 with a nonzero IR, then pull rst_f mid-cycle.
    imem[0] = 32'h2A00_0123;
    drive_cycle(0, 1, 0, 0, 1);
    drive_cycle(0, 1, 1, 1, 0);
    n_cmp++;
    if (bus.imem_addr !== 16'h0123) begin
      n_err++; $display("FAIL reset_setup_pc: got %h want 0123", bus.imem_addr);
    end
    @(negedge clk);
    #2;
    rst_f = 1'b0;
    #1;
    n_cmp++;
    if (bus.imem_addr !== 16'h0 || bus.ir !== 32'h0 || bus.halted !== 1'b0 ||
        bus.fetch_count !== 16'h0) begin
      n_err++;
      $display("FAIL reset_async: pc=%h ir=%h halted=%b cnt=%0d want 0/0/0/0",
               bus.imem_addr, bus.ir, bus.halted, bus.fetch_count);
    end
    idle_strobes();
    model_reset();
    @(negedge clk);
    rst_f = 1'b1;
  endtask

  task automatic test_seq_fetch();
    imem[0] = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFF);
    imem[1] = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFF);
    imem[2] = 32'h0000_0000 | ($urandom & 32'h0FFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 1, 0, 0, 1);
      n_cmp++;
      if (bus.ir !== imem[i] || bus.imem_addr !== 16'(i + 1)) begin
        n_err++;
        $display("FAIL seq_fetch_%0d: ir=%h pc=%h want ir=%h pc=%h", i, bus.ir,
                 bus.imem_addr, imem[i], 16'(i + 1));
      end
    end
    n_cmp++;
    if (bus.fetch_count !== 16'd3 || bus.opcode !== 4'h0) begin
      n_err++;
      $display("FAIL seq_fetch_count: cnt=%0d op=%h want 3/0", bus.fetch_count, bus.opcode);
    end
  endtask

  task automatic test_bra_abs();
    imem[m_pc] = 32'h2123_0040;
    drive_cycle(0, 0, 0, 0, 1);
    n_cmp++;
    if (bus.imm !== 16'h0040 || bus.mm !== 4'h1 || bus.rd !== 4'h2 || bus.rs !== 4'h3 ||
        bus.rt !== 4'h0) begin
      n_err++;
      $display("FAIL bra_fields: imm=%h mm=%h rd=%h rs=%h rt=%h want 0040/1/2/3/0",
               bus.imm, bus.mm, bus.rd, bus.rs, bus.rt);
    end
    drive_cycle(0, 1, 1, 1, 0);
    n_cmp++;
    if (bus.imem_addr !== 16'h0040) begin
      n_err++; $display("FAIL bra_abs: pc=%h want 0040", bus.imem_addr);
    end
  endtask

  task automatic test_brr_wrap();
    pulse_reset();
    imem[0] = 32'h3000_FFFD;
    drive_cycle(0, 1, 0, 0, 1);
    drive_cycle(0, 1, 0, 0, 0);
    n_cmp++;
    if (bus.imem_addr !== 16'h0002) begin
      n_err++; $display("FAIL brr_setup: pc=%h want 0002", bus.imem_addr);
    end
    drive_cycle(0, 1, 1, 0, 0);
    n_cmp++;
    if (bus.imem_addr !== 16'hFFFF) begin
      n_err++; $display("FAIL brr_wrap: pc=%h want ffff", bus.imem_addr);
    end
    drive_cycle(0, 1, 0, 0, 0);
    n_cmp++;
    if (bus.imem_addr !== 16'h0000) begin
      n_err++; $display("FAIL inc_wrap: pc=%h want 0000", bus.imem_addr);
    end
  endtask

  task automatic test_pc_rst();
    int cnt_before;
    imem[m_pc] = 32'h2000_0010;
    drive_cycle(0, 1, 0, 0, 1);
    cnt_before = m_cnt;
    drive_cycle(1, 1, 1, 1'($urandom), 0);
    n_cmp++;
    if (bus.imem_addr !== 16'h0 || bus.fetch_count !== 16'(cnt_before) ||
        bus.ir !== 32'h2000_0010) begin
      n_err++;
      $display("FAIL pc_rst_prio: pc=%h cnt=%0d ir=%h want 0000/%0d/20000010",
               bus.imem_addr, bus.fetch_count, bus.ir, cnt_before);
    end
  endtask

  task automatic test_halt();
    logic [15:0] pc_h;
    int          cnt_h;
    imem[m_pc] = 32'hF000_0000;
    drive_cycle(0, 1, 0, 0, 1);
    pc_h  = 16'(m_pc);
    cnt_h = m_cnt;
    n_cmp++;
    if (bus.halted !== 1'b1 || bus.ir !== 32'hF000_0000) begin
      n_err++; $display("FAIL halt_set: halted=%b ir=%h want 1/f0000000", bus.halted, bus.ir);
    end
    imem[m_pc] = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(0, 1, 1'($urandom), 1'($urandom), 1);
      n_cmp++;
      if (bus.imem_addr !== pc_h || bus.ir !== 32'hF000_0000 ||
          bus.fetch_count !== 16'(cnt_h) || bus.halted !== 1'b1) begin
        n_err++;
        $display("FAIL halt_hold_%0d: pc=%h ir=%h cnt=%0d h=%b want %h/f0000000/%0d/1", i,
                 bus.imem_addr, bus.ir, bus.fetch_count, bus.halted, pc_h, cnt_h);
      end
    end
    drive_cycle(1, 0, 0, 0, 0);
    n_cmp++;
    if (bus.imem_addr !== 16'h0 || bus.halted !== 1'b1) begin
      n_err++;
      $display("FAIL halt_pc_rst: pc=%h halted=%b want 0000/1", bus.imem_addr, bus.halted);
    end
    pulse_reset();
    n_cmp++;
    if (bus.halted !== 1'b0 || bus.fetch_count !== 16'h0) begin
      n_err++;
      $display("FAIL halt_clear: halted=%b cnt=%0d want 0/0", bus.halted, bus.fetch_count);
    end
  endtask

  task automatic test_random();
    bit rst, w, sel, br, ld;
    for (int a = 0; a < 65536; a++) imem[a] = $urandom;
    for (int i = 0; i < 400; i++) begin
      if (m_halted && ($urandom_range(0, 3) == 0)) pulse_reset();
      rst = ($urandom_range(0, 15) == 0);
      w   = 1'($urandom);
      sel = 1'($urandom);
      br  = 1'($urandom);
      ld  = 1'($urandom);
      drive_cycle(rst, w, sel, br, ld);
      n_cmp++;
      if (bus.imem_addr !== 16'(m_pc) || bus.ir !== m_ir || bus.halted !== m_halted ||
          bus.fetch_count !== 16'(m_cnt) || bus.opcode !== m_ir[31:28] ||
          bus.imm !== m_ir[15:0]) begin
        n_err++;
        $display("FAIL random_%0d: pc=%h ir=%h h=%b cnt=%0d want pc=%h ir=%h h=%b cnt=%0d",
                 i, bus.imem_addr, bus.ir, bus.halted, bus.fetch_count, 16'(m_pc), m_ir,
                 m_halted, m_cnt);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) imem[a] = '0;
    idle_strobes();
    model_reset();
    rst_f = 1'b0;
    #12;
    n_cmp++;
    if (bus.imem_addr !== 16'h0 || bus.ir !== 32'h0 || bus.halted !== 1'b0 ||
        bus.fetch_count !== 16'h0) begin
      n_err++;
      $display("FAIL reset_initial: pc=%h ir=%h halted=%b cnt=%0d want 0/0/0/0",
               bus.imem_addr, bus.ir, bus.halted, bus.fetch_count);
    end
    @(negedge clk);
    rst_f = 1'b1;

    test_reset();
    test_seq_fetch();
    test_bra_abs();
    test_brr_wrap();
    test_pc_rst();
    test_halt();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
